pcie_tx_arbiter: RTL

PCIE_TX_ARBITER -- requirements
Module: pcie_tx_arbiter

---
 rtl/pcie_tx_arbiter_pkg.sv | 51 +++++
 rtl/pcie_tx_skid.sv | 66 ++++++
 rtl/pcie_tx_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pcie_tx_arbiter_pkg.sv
// Shared PCIe TX definitions: arbiter state, grant encoding, TLP header types.
package pcie_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPL = 2'd1,
    OWN_REQ = 2'd2
  } arb_state_e;

  localparam int unsigned GNT_W = 2;
  localparam logic [GNT_W-1:0] GNT_NONE = 2'b00;
  localparam logic [GNT_W-1:0] GNT_CPL  = 2'b01;
  localparam logic [GNT_W-1:0] GNT_REQ  = 2'b10;

  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [2:0] FMT_4DW_DATA   = 3'b011;
  localparam logic [4:0] TYPE_MEM       = 5'b00000;
  localparam logic [4:0] TYPE_CPL       = 5'b01010;

  // First header DW common to all TLPs.
  typedef struct packed {
    logic [2:0] fmt;
    logic [4:0] tlp_type;
    logic       t9;
    logic [2:0] tc;
    logic       t8;
    logic       attr2;
    logic       ln;
    logic       th;
    logic       td;
    logic       ep;
    logic [1:0] attr;
    logic [1:0] at;
    logic [9:0] length;
  } tlp_hdr_dw0_t;

  // Completion-specific header DWs 1 and 2.
  typedef struct packed {
    logic [15:0] completer_id;
    logic [2:0]  cpl_status;
    logic        bcm;
    logic [11:0] byte_count;
    logic [15:0] requester_id;
    logic [7:0]  tag;
    logic        rsvd;
    logic [6:0]  lower_addr;
  } tlp_cpl_hdr_t;

endpackage

// File: rtl/pcie_tx_skid.sv
// Two-entry registered skid stage; in_ready is a flop so out_ready never reaches the input combinationally.
module pcie_tx_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         in_ready_q, in_ready_d;
  logic         accept;

  // Output register refills from the skid entry first, otherwise from the input.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    accept       = in_valid & in_ready_q;
    if (out_ready || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_data_d = in_data;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers; reset empties both entries and holds the input off.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Two-requester TLP arbiter (completions vs. requests) feeding the PCIe TX port, TLP-atomic.
module pcie_tx_arbiter #(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned EMPTY_W    = 3,
  parameter int unsigned PRIO_CPL   = 1,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cpl_valid,
  output logic               cpl_ready,
  input  logic               cpl_sop,
  input  logic               cpl_eop,
  input  logic [DATA_W-1:0]  cpl_data,
  input  logic [EMPTY_W-1:0] cpl_empty,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_sop,
  input  logic               req_eop,
  input  logic [DATA_W-1:0]  req_data,
  input  logic [EMPTY_W-1:0] req_empty,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_sop,
  output logic               tx_eop,
  output logic [DATA_W-1:0]  tx_data,
  output logic [EMPTY_W-1:0] tx_empty,
  output logic [1:0]         grant,
  output logic [15:0]        cnt_cpl,
  output logic [15:0]        cnt_req,
  output logic               err_sop
);
  import pcie_tx_arbiter_pkg::*;

  localparam int unsigned PAYLOAD_W = DATA_W + EMPTY_W + 2;
  localparam int unsigned STARVE_W  = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  arb_state_e          state_q, state_d;
  logic                last_req_q, last_req_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [15:0]         cnt_cpl_q, cnt_cpl_d;
  logic [15:0]         cnt_req_q, cnt_req_d;
  logic                err_sop_q, err_sop_d;
  logic [GNT_W-1:0]    grant_q, grant_d;

  logic                 elig_cpl, elig_req, pick_cpl, pick_req, bad_sop, starved;
  logic                 skid_in_valid, skid_in_ready;
  logic [PAYLOAD_W-1:0] skid_in_data, skid_out_data, cpl_pl, req_pl;

  assign cpl_pl = {cpl_sop, cpl_eop, cpl_empty, cpl_data};
  assign req_pl = {req_sop, req_eop, req_empty, req_data};

  // Winner selection, ownership tracking, counters and error flag.
  always_comb begin
    state_d       = state_q;
    last_req_d    = last_req_q;
    starve_d      = starve_q;
    cnt_cpl_d     = cnt_cpl_q;
    cnt_req_d     = cnt_req_q;
    err_sop_d     = err_sop_q;
    grant_d       = GNT_NONE;
    cpl_ready     = 1'b0;
    req_ready     = 1'b0;
    skid_in_valid = 1'b0;
    skid_in_data  = cpl_pl;
    elig_cpl      = cpl_valid & cpl_sop;
    elig_req      = req_valid & req_sop;
    pick_cpl      = 1'b0;
    pick_req      = 1'b0;
    bad_sop       = (cpl_valid & !cpl_sop) | (req_valid & !req_sop);
    starved       = (starve_q == STARVE_W'(STARVE_LIM));
    unique case (state_q)
      IDLE: begin
        if (elig_cpl && elig_req) begin
          if (PRIO_CPL != 0) pick_cpl = !starved;
          else               pick_cpl = last_req_q;
          pick_req = !pick_cpl;
        end else begin
          pick_cpl = elig_cpl;
          pick_req = elig_req;
        end
        // Mid-TLP beats seen while idle are swallowed so they never reach the link.
        cpl_ready     = skid_in_ready & (pick_cpl | (cpl_valid & !cpl_sop));
        req_ready     = skid_in_ready & (pick_req | (req_valid & !req_sop));
        skid_in_valid = pick_cpl | pick_req;
        skid_in_data  = pick_req ? req_pl : cpl_pl;
        if (skid_in_ready) begin
          if (bad_sop) err_sop_d = 1'b1;
          if (pick_cpl) begin
            last_req_d = 1'b0;
            grant_d    = GNT_CPL;
            if (elig_req && !starved) starve_d = starve_q + STARVE_W'(1);
            if (cpl_eop) cnt_cpl_d = cnt_cpl_q + 16'd1;
            else         state_d   = OWN_CPL;
          end else if (pick_req) begin
            last_req_d = 1'b1;
            grant_d    = GNT_REQ;
            starve_d   = '0;
            if (req_eop) cnt_req_d = cnt_req_q + 16'd1;
            else         state_d   = OWN_REQ;
          end
        end
      end
      OWN_CPL: begin
        cpl_ready     = skid_in_ready;
        skid_in_valid = cpl_valid;
        skid_in_data  = cpl_pl;
        grant_d       = GNT_CPL;
        if (cpl_valid && skid_in_ready && cpl_eop) begin
          cnt_cpl_d = cnt_cpl_q + 16'd1;
          state_d   = IDLE;
        end
      end
      OWN_REQ: begin
        req_ready     = skid_in_ready;
        skid_in_valid = req_valid;
        skid_in_data  = req_pl;
        grant_d       = GNT_REQ;
        if (req_valid && skid_in_ready && req_eop) begin
          cnt_req_d = cnt_req_q + 16'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_req_q <= 1'b1;
      starve_q   <= '0;
      cnt_cpl_q  <= '0;
      cnt_req_q  <= '0;
      err_sop_q  <= 1'b0;
      grant_q    <= GNT_NONE;
    end else begin
      state_q    <= state_d;
      last_req_q <= last_req_d;
      starve_q   <= starve_d;
      cnt_cpl_q  <= cnt_cpl_d;
      cnt_req_q  <= cnt_req_d;
      err_sop_q  <= err_sop_d;
      grant_q    <= grant_d;
    end
  end

  pcie_tx_skid #(
    .W(PAYLOAD_W)
  ) u_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (skid_in_valid),
    .in_ready (skid_in_ready),
    .in_data  (skid_in_data),
    .out_valid(tx_valid),
    .out_ready(tx_ready),
    .out_data (skid_out_data)
  );

  assign {tx_sop, tx_eop, tx_empty, tx_data} = skid_out_data;
  assign grant   = grant_q;
  assign cnt_cpl = cnt_cpl_q;
  assign cnt_req = cnt_req_q;
  assign err_sop = err_sop_q;

endmodule
